// File: rtl/router_pkg.sv
// Shared types and constants for the router 1x3 destination FIFOs.
package router_pkg;

  localparam int ROUTER_DW         = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int TIMEOUT_CYCLES    = 30;

  typedef struct packed {
    logic       lfd;
    logic [7:0] data;
  } fifo_entry_t;

  typedef logic [5:0] pkt_len_t;

endpackage

// File: rtl/router_fifo_timer.sv
// Stall timer for a destination FIFO: flushes the FIFO when the agent leaves data unread too long.
// Compiled only when ROUTER_FIFO_TIMEOUT_EN is defined.
`ifdef ROUTER_FIFO_TIMEOUT_EN
module router_fifo_timer
  import router_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic read_i,
  output logic flush_o
);

  logic [4:0] cnt_q;
  logic [4:0] cnt_d;

  assign flush_o = (cnt_q == 5'(TIMEOUT_CYCLES));

  // A flush, any read, or a drained FIFO restarts the stall window.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_o || read_i || !valid_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/router_dest_fifo.sv
// Per-destination output FIFO with packet-boundary tracking on the read side.
// Optional stall flush enabled by defining ROUTER_FIFO_TIMEOUT_EN.
module router_dest_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int DW    = ROUTER_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          soft_reset,
  input  logic          write_enb,
  input  logic          lfd_state,
  input  logic [DW-1:0] data_in,
  input  logic          read_enb,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          full,
  output logic          empty,
  output logic          pkt_rd_done
);

  localparam int AW = $clog2(DEPTH);

  logic [DW:0]   mem_q [DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [6:0]    count_q, count_d;
  logic [DW-1:0] dataOut_q, dataOut_d;
  logic          pktDone_q, pktDone_d;

  logic          flushTimeout;
  logic          clearAll;
  logic          doWrite;
  logic          doRead;
  logic [DW:0]   rdEntry;
  pkt_len_t      hdrLen;

`ifdef ROUTER_FIFO_TIMEOUT_EN
  router_fifo_timer uTimer (
    .clk     (clk),
    .reset   (reset | soft_reset),
    .valid_i (valid_out),
    .read_i  (read_enb),
    .flush_o (flushTimeout)
  );
`else
  assign flushTimeout = 1'b0;
`endif

  assign clearAll  = reset | soft_reset | flushTimeout;

  assign empty     = (wrPtr_q == rdPtr_q);
  assign full      = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign valid_out = ~empty;

  assign doWrite   = write_enb & ~full;
  assign doRead    = read_enb & ~empty;

  assign rdEntry   = mem_q[rdPtr_q[AW-1:0]];
  assign hdrLen    = rdEntry[7:2];

  // Header reads (re)load payload+parity length; the final byte of a packet raises the done pulse.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    dataOut_d = dataOut_q;
    pktDone_d = 1'b0;
    if (doWrite) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doRead) begin
      rdPtr_d   = rdPtr_q + 1'b1;
      dataOut_d = rdEntry[DW-1:0];
      if (rdEntry[DW]) begin
        count_d = {1'b0, hdrLen} + 7'd1;
      end else if (count_q != 7'd0) begin
        count_d = count_q - 7'd1;
        if (count_q == 7'd1) begin
          pktDone_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clearAll) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      dataOut_q <= '0;
      pktDone_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dataOut_q <= dataOut_d;
      pktDone_q <= pktDone_d;
    end
  end

  // Storage is deliberately never cleared; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (doWrite && !clearAll) begin
      mem_q[wrPtr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out    = dataOut_q;
  assign pkt_rd_done = pktDone_q;

endmodule

// File: doc/router_dest_fifo.md
Name: router_dest_fifo

Overview:
- Per-destination output FIFO of the router 1x3; three instances, one per output port.
- Buffers bytes written by the router FSM/register path.
- Presents them to the destination agent over data_out / valid_out / read_enb, so it sits directly upstream of the destination interface.
- Tracks packet boundaries so the header and payload length are known on the read side.

Parameters:
- DEPTH, 16, number of storage entries; power of two, minimum 4.
- DW, 8, data byte width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears pointers, counters and outputs.
- soft_reset  input  1  synchronous flush from router sync block; same effect as reset.
- write_enb  input  1  write strobe from router FSM.
- lfd_state  input  1  high with the write of a header byte (load-first-data).
- data_in  input  DW  byte to store.
- read_enb  input  1  read strobe from destination agent.
- data_out  output  DW  registered read data.
- valid_out  output  1  FIFO non-empty.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- pkt_rd_done  output  1  one-cycle pulse when the last byte of a packet (parity) is read.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset.
- Storage: DEPTH entries of DW+1 bits, {lfd, byte}.
- Pointers: wr_ptr/rd_ptr are log2(DEPTH)+1 bits, with the MSB as wrap bit.
- Flags:
  - empty = pointers equal.
  - full = indexes equal and MSBs differ.
  - valid_out = ~empty.
  - All flags are combinational from registered pointers.
- Write: when write_enb & ~full, store {lfd_state, data_in} at wr_ptr and increment it. Writes while full are dropped and not stored.
- Read: when read_enb & ~empty, data_out <= byte at rd_ptr and rd_ptr increments. Latency is one cycle from read_enb to data_out. With no read, data_out holds its value. Reads while empty are ignored and data_out holds.
- Simultaneous read and write:
  - Both are honoured when ~full and ~empty.
  - When empty, only the write is taken; valid_out rises the next cycle.
  - When full, only the read is taken; full falls the next cycle. The write is not accepted in the same cycle.
- Packet counter (7 bits):
  - Reading an entry with lfd=1 loads count <= byte[7:2] + 1 (payload length plus parity).
  - Reading a non-header byte when count != 0 decrements count.
  - The read that takes count from 1 to 0 asserts pkt_rd_done for one cycle.
  - A header read while count != 0 reloads the counter; the truncated packet produces no pulse.
- Pointer wrap: natural modulo 2*DEPTH, with no special case.
- Reset or soft_reset (soft_reset priority equal to reset):
  - Pointers reset to 0.
  - count reset to 0.
  - data_out reset to 0.
  - pkt_rd_done reset to 0.
  - Storage is not cleared.
  - Post-reset outputs: empty=1, full=0, valid_out=0.
  - A write or read in the same cycle as reset is discarded.

Optional Feature:
- ROUTER_FIFO_TIMEOUT_EN defined:
  - An internal 5-bit timer counts consecutive cycles with valid_out=1 and read_enb=0.
  - Any read clears the timer.
  - On reaching 30 the timer asserts an internal flush, ORed with soft_reset, on the next edge. The FIFO empties and the timer clears.
- Undefined: no timer; flushing happens only via reset or the soft_reset port.

Decomposition:
- Package router_pkg:
  - ROUTER_DW = 8.
  - ROUTER_FIFO_DEPTH = 16.
  - TIMEOUT_CYCLES = 30.
  - typedef fifo_entry_t as packed struct {logic lfd; logic [7:0] data;}.
  - typedef pkt_len_t as logic [5:0].
- Sub-module router_fifo_timer: timeout counter and flush pulse. Instantiated only under ROUTER_FIFO_TIMEOUT_EN.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> empty=1, valid_out=0, data_out=8'h00, pkt_rd_done=0.
- Packet pass-through:
  - Write header 8'h0D (len 3) with lfd_state=1, then 8'hA1, 8'hA2, 8'hA3 and parity 8'h5C, then read 5 times.
  - Required: data_out sequence 0D, A1, A2, A3, 5C, each one cycle after its read_enb.
  - Required: pkt_rd_done pulses on the 5C read only.
- Full boundary:
  - Write 17 bytes 8'h00..8'h10 with no reads -> full=1 after the 16th; 8'h10 is dropped.
  - Then read 16 -> last data_out = 8'h0F, empty=1.
- Simultaneous read and write at full:
  - Fill with 16 bytes, then write_enb=1 & read_enb=1 in the same cycle.
  - Required: read returns the oldest byte, the write is dropped, full=0 next cycle.
- Soft reset mid-packet: 3 bytes queued, pulse soft_reset -> valid_out=0 next cycle, data_out=0, a later read is ignored.
- Timeout (macro defined): write 1 byte, hold read_enb=0 -> flush after 30 cycles, valid_out=0 on cycle 31. With the macro undefined, valid_out stays 1.
